// File: rtl/bcd_serial_add_ctrl_pkg.sv
// bcd_serial_add_ctrl_pkg: shared state encodings and BCD constants
package bcd_serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_ADJ = 4'd6;

    function automatic logic is_bcd(input logic [3:0] nib);
        return nib <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// bcd_serial_add_ctrl_if: start/busy/done request bus between requester and sequencer
interface bcd_serial_add_ctrl_if #(
    parameter int DIGITS = 4
);

    logic                  start;
    logic [4*DIGITS-1:0]   op_a;
    logic [4*DIGITS-1:0]   op_b;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   sum;
    logic                  carry_out;
    logic                  err;

    modport master (
        output start, op_a, op_b,
        input  busy, done, sum, carry_out, err
    );

    modport slave (
        input  start, op_a, op_b,
        output busy, done, sum, carry_out, err
    );

endinterface

// File: rtl/bcd_serial_add_ctrl_digit_add.sv
// bcd_digit_add: combinational single-digit BCD adder with decimal carry
module bcd_digit_add
    import bcd_serial_add_ctrl_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] digit,
    output logic       cout
);

    logic [4:0] s;

    assign s     = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    assign cout  = s > {1'b0, BCD_MAX};
    assign digit = cout ? s[3:0] + BCD_ADJ : s[3:0];

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl: steps one BCD digit adder across DIGITS positions, LSD first
module bcd_serial_add_ctrl
    import bcd_serial_add_ctrl_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int CNT_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    bcd_serial_add_ctrl_if.slave     bus
);

    state_t                state, next;
    logic [4*DIGITS-1:0]   a_q, b_q, sum_q;
    logic [CNT_W-1:0]      idx;
    logic                  carry, carry_out_q, err_q;
    logic [2*DIGITS-1:0]   nib_ok;
    logic                  ops_ok, last;
    logic [3:0]            da, db, digit;
    logic                  cout;
    logic                  busy, done;

    for (genvar g = 0; g < DIGITS; g++) begin : g_chk
        assign nib_ok[g]          = is_bcd(bus.op_a[4*g +: 4]);
        assign nib_ok[DIGITS + g] = is_bcd(bus.op_b[4*g +: 4]);
    end

    assign ops_ok = &nib_ok;
    assign last   = idx == CNT_W'(DIGITS - 1);
    assign da     = a_q[4*idx +: 4];
    assign db     = b_q[4*idx +: 4];

    bcd_digit_add u_add (
        .a     (da),
        .b     (db),
        .cin   (carry),
        .digit (digit),
        .cout  (cout)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next;
    end

    // next state and handshake outputs
    always_comb begin
        next = state;
        busy = state != ST_IDLE;
        done = state == ST_DONE;
        unique case (state)
            ST_IDLE: if (bus.start) next = ops_ok ? ST_ADD : ST_DONE;
            ST_ADD:  if (last) next = ST_DONE;
            ST_DONE: next = ST_IDLE;
            default: next = ST_IDLE;
        endcase
    end

    // operand capture, digit stepping and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx         <= '0;
            carry       <= 1'b0;
            carry_out_q <= 1'b0;
            err_q       <= 1'b0;
        end else if (state == ST_IDLE && bus.start) begin
            a_q         <= bus.op_a;
            b_q         <= bus.op_b;
            sum_q       <= '0;
            idx         <= '0;
            carry       <= 1'b0;
            carry_out_q <= 1'b0;
            err_q       <= !ops_ok;
        end else if (state == ST_ADD) begin
            sum_q[4*idx +: 4] <= digit;
            carry             <= cout;
            idx               <= idx + 1'b1;
            if (last) carry_out_q <= cout;
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_out_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb_bcd_serial_add_ctrl: directed and random checks against a decimal-arithmetic model
module tb_bcd_serial_add_ctrl;

    localparam int DIGITS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad = 0;

    bcd_serial_add_ctrl_if #(.DIGITS(DIGITS)) bus ();

    bcd_serial_add_ctrl #(.DIGITS(DIGITS), .CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic valid(input logic [15:0] x);
        for (int i = 0; i < DIGITS; i++) if (x[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int to_dec(input logic [15:0] x);
        int v = 0;
        for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(x[4*i +: 4]);
        return v;
    endfunction

    // returns {err, carry, sum}
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r = '0;
        int t;
        if (!valid(a) || !valid(b)) return {2'b10, 16'h0};
        t = to_dec(a) + to_dec(b);
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((t / (10 ** i)) % 10);
        end
        return {1'b0, t >= 10000, r};
    endfunction

    function automatic logic [15:0] rand_bcd();
        logic [15:0] r;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // waits up to a bound for done after the acceptance edge, then checks results
    task automatic wait_check(input string tag, input logic [15:0] a, input logic [15:0] b);
        logic [17:0] e;
        int k;
        e = model(a, b);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.done && k < 20);
        chk({tag, " lat"}, 32'(k), e[17] ? 32'd1 : 32'(DIGITS + 1));
        chk({tag, " busy"}, 32'(bus.busy), 32'd1);
        chk({tag, " sum"}, 32'(bus.sum), 32'(e[15:0]));
        chk({tag, " cout"}, 32'(bus.carry_out), 32'(e[16]));
        chk({tag, " err"}, 32'(bus.err), 32'(e[17]));
    endtask

    task automatic req(input string tag, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op_a  = 16'hFFFF;
        bus.op_b  = 16'hFFFF;
        wait_check(tag, a, b);
        @(negedge clk);
        chk({tag, " pulse"}, 32'(bus.done), 32'd0);
        chk({tag, " idle"}, 32'(bus.busy), 32'd0);
        chk({tag, " hold"}, 32'(bus.sum), 32'(model(a, b) & 18'hFFFF));
    endtask

    initial begin
        logic [15:0] a, b, a1;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        #3 rst_n = 1'b0;
        #1;
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst sum", 32'(bus.sum), 32'd0);
        chk("rst cout", 32'(bus.carry_out), 32'd0);
        chk("rst err", 32'(bus.err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        req("1234+5678", 16'h1234, 16'h5678);
        req("9999+0001", 16'h9999, 16'h0001);
        req("9999+9999", 16'h9999, 16'h9999);
        req("0000+0000", 16'h0000, 16'h0000);
        req("bad nibble", 16'h12A4, 16'h0001);
        req("clear err", 16'h0456, 16'h0544);
        req("bad op_b", 16'h0000, 16'hF000);

        for (int n = 0; n < 25; n++) req("rand", rand_bcd(), rand_bcd());
        for (int n = 0; n < 6; n++) begin
            a = rand_bcd();
            a[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
            if (n[0]) req("rand bad", a, rand_bcd());
            else      req("rand bad", rand_bcd(), a);
        end

        // start held high: only operands at each IDLE acceptance count
        @(negedge clk);
        a = rand_bcd();
        b = rand_bcd();
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        @(posedge clk);
        for (int k = 0; k < 20 && !bus.done; k++) begin
            @(negedge clk);
            if (!bus.done) begin
                bus.op_a = rand_bcd();
                bus.op_b = rand_bcd();
            end
        end
        chk("held sum", 32'(bus.sum), 32'(model(a, b) & 18'hFFFF));
        chk("held cout", 32'(bus.carry_out), 32'(model(a, b) >> 16));
        bus.op_a = rand_bcd();
        bus.op_b = rand_bcd();
        @(negedge clk);
        chk("held idle", 32'(bus.busy), 32'd0);
        a1 = rand_bcd();
        a = a1;
        b = rand_bcd();
        bus.op_a = a;
        bus.op_b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op_a  = 16'h0000;
        bus.op_b  = 16'h0000;
        wait_check("held 2nd", a, b);

        // reset in the middle of an addition with idx=2
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = 16'h1234;
        bus.op_b  = 16'h5678;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("mid partial", 32'(bus.sum), 32'h0012);
        rst_n = 1'b0;
        #1;
        chk("mid busy", 32'(bus.busy), 32'd0);
        chk("mid done", 32'(bus.done), 32'd0);
        chk("mid sum", 32'(bus.sum), 32'd0);
        chk("mid cout", 32'(bus.carry_out), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("mid nodone", 32'(bus.done), 32'd0);
        end
        rst_n = 1'b1;
        req("0005+0005", 16'h0005, 16'h0005);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
